// File: rtl/vector_sel_pkg.sv
// Shared types and widths for the vector selection unit.
// Mode encodings match the 3-bit mode field on the datapath bus.
package vector_sel_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    MODE_PASS      = 3'b000,
    MODE_BYTE_REV  = 3'b001,
    MODE_BIT_REV   = 3'b010,
    MODE_HALF_SWAP = 3'b011,
    MODE_NIB_SWAP  = 3'b100,
    MODE_ZEXT_BYTE = 3'b101,
    MODE_SEXT_BYTE = 3'b110,
    MODE_RSVD      = 3'b111
  } vsel_mode_e;

  // Even parity per byte: bit k is the XOR of byte k.
  function automatic logic [3:0] byte_parity(input logic [WORD_W-1:0] w);
    logic [3:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) begin
      p[k] = ^w[BYTE_W*k +: BYTE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/vector_sel_unit_if.sv
// Request/result bus of vector_sel_unit; parity only exists with VECTOR_SEL_PARITY_EN.
// master drives the request and observes the result; slave is the unit itself.
interface vector_sel_unit_if;
  import vector_sel_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in;
  logic [2:0]        mode;
  logic [1:0]        byte_sel;
  logic              out_valid;
  logic [WORD_W-1:0] out;
`ifdef VECTOR_SEL_PARITY_EN
  logic [3:0]        parity;

  modport master (output in_valid, in, mode, byte_sel, input out_valid, out, parity);
  modport slave  (input in_valid, in, mode, byte_sel, output out_valid, out, parity);
`else
  modport master (output in_valid, in, mode, byte_sel, input out_valid, out);
  modport slave  (input in_valid, in, mode, byte_sel, output out_valid, out);
`endif

endinterface

// File: rtl/vector_sel_perm.sv
// Combinational permute/extract of one 32-bit word selected by mode.
// No clock, no state; byte_sel only matters for the two extract modes.
module vector_sel_perm
  import vector_sel_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  vsel_mode_e        mode,
  input  logic [1:0]        byte_sel,
  output logic [WORD_W-1:0] result
);

  logic [BYTE_W-1:0] sel_byte;

  always_comb begin
    sel_byte = '0;
    case (byte_sel)
      2'd0:    sel_byte = in[7:0];
      2'd1:    sel_byte = in[15:8];
      2'd2:    sel_byte = in[23:16];
      default: sel_byte = in[31:24];
    endcase
  end

  always_comb begin
    result = '0;
    case (mode)
      MODE_PASS:      result = in;
      MODE_BYTE_REV:  result = {in[7:0], in[15:8], in[23:16], in[31:24]};
      MODE_BIT_REV: begin
        for (int i = 0; i < WORD_W; i++) begin
          result[i] = in[WORD_W-1-i];
        end
      end
      MODE_HALF_SWAP: result = {in[15:0], in[31:16]};
      MODE_NIB_SWAP: begin
        for (int k = 0; k < 4; k++) begin
          result[BYTE_W*k     +: 4] = in[BYTE_W*k + 4 +: 4];
          result[BYTE_W*k + 4 +: 4] = in[BYTE_W*k     +: 4];
        end
      end
      MODE_ZEXT_BYTE: result = {24'h0, sel_byte};
      MODE_SEXT_BYTE: result = {{24{sel_byte[7]}}, sel_byte};
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/vector_sel_unit.sv
// vector_sel_unit: registered permute/extract; optional per-byte parity via VECTOR_SEL_PARITY_EN.
// Latency 1 cycle; no backpressure, one result per accepted in_valid.
module vector_sel_unit
  import vector_sel_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  vector_sel_unit_if.slave   bus
);

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] out_q;
  logic             vld_q;

  vector_sel_perm u_perm (
    .in       (bus.in),
    .mode     (vsel_mode_e'(bus.mode)),
    .byte_sel (bus.byte_sel),
    .result   (result)
  );

  // out holds its last value when idle; out_valid only flags new results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= result;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;

`ifdef VECTOR_SEL_PARITY_EN
  logic [3:0] par_q;

  // Loaded on the same edge as out so the two never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (bus.in_valid) begin
      par_q <= byte_parity(result);
    end
  end

  assign bus.parity = par_q;
`endif

endmodule

// File: tb/tb_vector_sel_unit.sv
// Self-checking bench for vector_sel_unit with a word-level reference model.
module tb_vector_sel_unit;
  import vector_sel_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vector_sel_unit_if bus ();

  vector_sel_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference transform written with shifts and masks on whole words.
  function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [2:0] m,
                                        input logic [1:0] s);
    logic [31:0] r;
    logic [31:0] b;
    r = 32'h0;
    b = (x >> (8 * int'(s))) & 32'hFF;
    case (m)
      3'd0: r = x;
      3'd1: r = ((x & 32'hFF) << 24) | ((x & 32'hFF00) << 8) |
                ((x >> 8) & 32'hFF00) | (x >> 24);
      3'd2: for (int i = 0; i < 32; i++) r = (r << 1) | ((x >> i) & 32'h1);
      3'd3: r = (x << 16) | (x >> 16);
      3'd4: r = ((x & 32'h0F0F0F0F) << 4) | ((x >> 4) & 32'h0F0F0F0F);
      3'd5: r = b;
      3'd6: r = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] ref_par(input logic [31:0] x);
    logic [3:0] p;
    int ones;
    p = 4'h0;
    for (int k = 0; k < 4; k++) begin
      ones = $countones((x >> (8 * k)) & 32'hFF);
      p[k] = (ones % 2) == 1;
    end
    return p;
  endfunction

  task automatic drive(input logic v, input logic [31:0] x, input logic [2:0] m,
                       input logic [1:0] s);
    bus.in_valid = v;
    bus.in       = x;
    bus.mode     = m;
    bus.byte_sel = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'hFFFFFFFF, 3'd0, 2'd0);
    tick();
    tick();
    total++;
    if (bus.out !== 32'h0) begin
      bad++; $display("FAIL reset_out: got %h want %h", bus.out, 32'h0);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_vld: got %b want 0", bus.out_valid);
    end
`ifdef VECTOR_SEL_PARITY_EN
    total++;
    if (bus.parity !== 4'h0) begin
      bad++; $display("FAIL reset_par: got %b want 0000", bus.parity);
    end
`endif
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 2'd0);
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle_vld: got %b want 0", bus.out_valid);
    end
    drive(1'b1, 32'h12345678, 3'd0, 2'd0);
    tick();
    total++;
    if (bus.out !== 32'h12345678 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL first_result: got %h/%b want 12345678/1", bus.out, bus.out_valid);
    end
  endtask

  task automatic test_mode_sweep();
    logic [2:0]  modes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] want  [6] = '{32'h13E589A8, 32'hA889E513, 32'h1591A7C8,
                               32'h89A813E5, 32'h315E988A, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h13E589A8, modes[i], 2'(i));
      tick();
      total++;
      if (bus.out !== want[i] || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL mode_sweep[%0d]: got %h/%b want %h/1", modes[i], bus.out, bus.out_valid, want[i]);
      end
    end
  endtask

  task automatic test_extract();
    logic [2:0]  modes [4] = '{3'd5, 3'd6, 3'd6, 3'd5};
    logic [1:0]  sels  [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    logic [31:0] want  [4] = '{32'h00000089, 32'hFFFFFFB0, 32'h0000005D, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hB0895D00, modes[i], sels[i]);
      tick();
      total++;
      if (bus.out !== want[i] || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL extract[%0d]: got %h/%b want %h/1", i, bus.out, bus.out_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 32'hF207CB89, 3'd3, 2'd0);
    tick();
    total++;
    if (bus.out !== 32'hCB89F207) begin
      bad++; $display("FAIL hold_load: got %h want CB89F207", bus.out);
    end
    drive(1'b0, 32'h79483762, 3'd0, 2'd0);
    tick();
    total++;
    if (bus.out !== 32'hCB89F207 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_keep: got %h/%b want CB89F207/0", bus.out, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins  [3] = '{32'h00F3D304, 32'h0000D000, 32'hB1F05663};
    logic [31:0] want [3] = '{32'h04D3F300, 32'h00D00000, 32'h6356F0B1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 3'd1, 2'd0);
      tick();
      total++;
      if (bus.out !== want[i] || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, bus.out, bus.out_valid, want[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'hDEADBEEF, 3'd0, 2'd0);
    rst_n = 1'b0;
    tick();
    total++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got %h/%b want 00000000/0", bus.out, bus.out_valid);
    end
    rst_n = 1'b1;
    drive(1'b1, 32'hA5C30F81, 3'd2, 2'd0);
    tick();
    total++;
    if (bus.out !== ref_f(32'hA5C30F81, 3'd2, 2'd0) || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_resume: got %h/%b want %h/1", bus.out, bus.out_valid,
               ref_f(32'hA5C30F81, 3'd2, 2'd0));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_out;
    logic        exp_vld;
    logic [31:0] x;
    logic [2:0]  m;
    logic [1:0]  s;
    logic        v;
    exp_out = bus.out === 32'hx ? 32'h0 : ref_f(32'hA5C30F81, 3'd2, 2'd0);
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      x = $urandom;
      m = 3'($urandom_range(0, 7));
      s = 2'($urandom_range(0, 3));
      drive(v, x, m, s);
      tick();
      if (v) exp_out = ref_f(x, m, s);
      exp_vld = v;
      total++;
      if (bus.out !== exp_out || bus.out_valid !== exp_vld) begin
        bad++;
        $display("FAIL random[%0d] in=%h mode=%0d sel=%0d: got %h/%b want %h/%b",
                 n, x, m, s, bus.out, bus.out_valid, exp_out, exp_vld);
      end
`ifdef VECTOR_SEL_PARITY_EN
      total++;
      if (bus.parity !== ref_par(exp_out)) begin
        bad++; $display("FAIL random_par[%0d]: got %b want %b", n, bus.parity, ref_par(exp_out));
      end
`endif
    end
  endtask

`ifdef VECTOR_SEL_PARITY_EN
  task automatic test_parity();
    logic [31:0] ins [2] = '{32'h00F3D304, 32'h0000D000};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ins[i], 3'd0, 2'd0);
      tick();
      total++;
      if (bus.parity !== ref_par(ins[i])) begin
        bad++; $display("FAIL parity[%0d]: got %b want %b", i, bus.parity, ref_par(ins[i]));
      end
    end
    drive(1'b0, 32'h0, 3'd0, 2'd0);
    rst_n = 1'b0;
    tick();
    total++;
    if (bus.parity !== 4'h0) begin
      bad++; $display("FAIL parity_reset: got %b want 0000", bus.parity);
    end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 2'd0);
    test_reset();
    test_mode_sweep();
    test_extract();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef VECTOR_SEL_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
